// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: a Moore FSM that sequences fetch, decode, execute, memory
// and writeback over a shared ALU/memory datapath and counts retired instructions.
module multicycle_control_fsm #(
    parameter bit          SUPPORT_JALR  = 1'b1,
    parameter bit          SUPPORT_UTYPE = 1'b1,
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [6:0]       op_i,
    input  logic [2:0]       funct3_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             adr_src_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             reg_write_o,
    output logic [1:0]       result_src_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic [2:0]       imm_src_o,
    output logic             illegal_op_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StJal,
        StJalrAdr,
        StBranch,
        StLui,
        StAuipc,
        StIllegal
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic mem_rdy;
    logic pc_update, branch;
    logic mem_write_raw, ir_write_raw, reg_write_raw, retire_raw;

    assign mem_rdy = MEM_HANDSHAKE ? mem_ready_i : 1'b1;

    always_comb begin
        state_d       = state_q;
        pc_update     = 1'b0;
        branch        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        retire_raw    = 1'b0;
        adr_src_o     = 1'b0;
        result_src_o  = 2'b00;
        alu_src_a_o   = 2'b00;
        alu_src_b_o   = 2'b00;
        alu_op_o      = 2'b00;
        illegal_op_o  = 1'b0;

        case (state_q)
            StFetch: begin
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                ir_write_raw = mem_rdy;
                pc_update    = mem_rdy;
                if (mem_rdy) state_d = StDecode;
            end
            StDecode: begin
                // Precompute the branch/jal target into ALUOut.
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                case (op_i)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIAlu:          state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = SUPPORT_JALR ? StJalrAdr : StIllegal;
                    OpBranch:        state_d = (funct3_i[2:1] == 2'b00) ? StBranch : StIllegal;
                    OpLui:           state_d = SUPPORT_UTYPE ? StLui : StIllegal;
                    OpAuipc:         state_d = SUPPORT_UTYPE ? StAuipc : StIllegal;
                    default:         state_d = StIllegal;
                endcase
            end
            StMemAdr: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                state_d     = op_i[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                adr_src_o = 1'b1;
                if (mem_rdy) state_d = StMemWb;
            end
            StMemWb: begin
                result_src_o  = 2'b01;
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
                state_d       = StFetch;
            end
            StMemWrite: begin
                adr_src_o     = 1'b1;
                mem_write_raw = 1'b1;
                retire_raw    = mem_rdy;
                if (mem_rdy) state_d = StFetch;
            end
            StExecR: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 2'b10;
                state_d     = StAluWb;
            end
            StExecI: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                alu_op_o    = 2'b10;
                state_d     = StAluWb;
            end
            StAluWb: begin
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
                state_d       = StFetch;
            end
            StJal: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_update   = 1'b1;
                state_d     = StAluWb;
            end
            StJalrAdr: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                state_d     = StJal;
            end
            StBranch: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 2'b01;
                branch      = 1'b1;
                retire_raw  = 1'b1;
                state_d     = StFetch;
            end
            StLui: begin
                alu_src_a_o = 2'b11;
                alu_src_b_o = 2'b01;
                state_d     = StAluWb;
            end
            StAuipc: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                state_d     = StAluWb;
            end
            StIllegal: begin
                illegal_op_o = 1'b1;
            end
            default: begin
                state_d = StIllegal;
            end
        endcase
    end

    // Strobes are forced low for as long as reset is held, not just after the next edge.
    assign pc_write_o  = rst_ni & (pc_update | (branch & (zero_i ^ funct3_i[0])));
    assign mem_write_o = rst_ni & mem_write_raw;
    assign ir_write_o  = rst_ni & ir_write_raw;
    assign reg_write_o = rst_ni & reg_write_raw;
    assign retire_o    = rst_ni & retire_raw;

    always_comb begin
        imm_src_o = 3'b000;
        case (op_i)
            OpStore:        imm_src_o = 3'b001;
            OpBranch:       imm_src_o = 3'b010;
            OpJal:          imm_src_o = 3'b011;
            OpLui, OpAuipc: imm_src_o = 3'b100;
            default:        imm_src_o = 3'b000;
        endcase
    end

    assign instret_d = retire_raw ? instret_q + CNT_W'(1) : instret_q;
    assign instret_o = instret_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StFetch;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: default instance, a jalr-disabled instance and a
// 4-bit instret instance share one stimulus stream.
module tb_multicycle_control_fsm;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b1;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    // Output signature: {pcw, adr, memw, irw, regw, res[2], a[2], b[2], aluop[2], ill, ret}
    localparam logic [14:0] S_FETCH_W = 15'b00000_10_00_10_00_0_0;
    localparam logic [14:0] S_FETCH   = 15'b10010_10_00_10_00_0_0;
    localparam logic [14:0] S_DECODE  = 15'b00000_00_01_01_00_0_0;
    localparam logic [14:0] S_MEMADR  = 15'b00000_00_10_01_00_0_0;
    localparam logic [14:0] S_MEMREAD = 15'b01000_00_00_00_00_0_0;
    localparam logic [14:0] S_MEMWB   = 15'b00001_01_00_00_00_0_1;
    localparam logic [14:0] S_MEMWR_W = 15'b01100_00_00_00_00_0_0;
    localparam logic [14:0] S_EXECR   = 15'b00000_00_10_00_10_0_0;
    localparam logic [14:0] S_ALUWB   = 15'b00001_00_00_00_00_0_1;
    localparam logic [14:0] S_JAL     = 15'b10000_00_01_10_00_0_0;
    localparam logic [14:0] S_JALRADR = 15'b00000_00_10_01_00_0_0;
    localparam logic [14:0] S_BR_T    = 15'b10000_00_10_00_01_0_1;
    localparam logic [14:0] S_BR_N    = 15'b00000_00_10_00_01_0_1;
    localparam logic [14:0] S_LUI     = 15'b00000_00_11_01_00_0_0;
    localparam logic [14:0] S_ILL     = 15'b00000_00_00_00_00_1_0;

    logic       d_pcw, d_adr, d_memw, d_irw, d_regw, d_ill, d_ret;
    logic [1:0] d_res, d_a, d_b, d_aop;
    logic [2:0] d_imm;
    logic [31:0] d_instret;
    logic       n_pcw, n_adr, n_memw, n_irw, n_regw, n_ill, n_ret;
    logic [1:0] n_res, n_a, n_b, n_aop;
    logic [2:0] n_imm;
    logic [31:0] n_instret;
    logic       c_pcw, c_adr, c_memw, c_irw, c_regw, c_ill, c_ret;
    logic [1:0] c_res, c_a, c_b, c_aop;
    logic [2:0] c_imm;
    logic [3:0] c_instret;

    multicycle_control_fsm dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .op_i(op), .funct3_i(funct3), .zero_i(zero),
        .mem_ready_i(mem_ready), .pc_write_o(d_pcw), .adr_src_o(d_adr), .mem_write_o(d_memw),
        .ir_write_o(d_irw), .reg_write_o(d_regw), .result_src_o(d_res), .alu_src_a_o(d_a),
        .alu_src_b_o(d_b), .alu_op_o(d_aop), .imm_src_o(d_imm), .illegal_op_o(d_ill),
        .retire_o(d_ret), .instret_o(d_instret)
    );

    multicycle_control_fsm #(.SUPPORT_JALR(1'b0)) dut_nj (
        .clk_i(clk_i), .rst_ni(rst_ni), .op_i(op), .funct3_i(funct3), .zero_i(zero),
        .mem_ready_i(mem_ready), .pc_write_o(n_pcw), .adr_src_o(n_adr), .mem_write_o(n_memw),
        .ir_write_o(n_irw), .reg_write_o(n_regw), .result_src_o(n_res), .alu_src_a_o(n_a),
        .alu_src_b_o(n_b), .alu_op_o(n_aop), .imm_src_o(n_imm), .illegal_op_o(n_ill),
        .retire_o(n_ret), .instret_o(n_instret)
    );

    multicycle_control_fsm #(.CNT_W(4)) dut_c4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .op_i(op), .funct3_i(funct3), .zero_i(zero),
        .mem_ready_i(mem_ready), .pc_write_o(c_pcw), .adr_src_o(c_adr), .mem_write_o(c_memw),
        .ir_write_o(c_irw), .reg_write_o(c_regw), .result_src_o(c_res), .alu_src_a_o(c_a),
        .alu_src_b_o(c_b), .alu_op_o(c_aop), .imm_src_o(c_imm), .illegal_op_o(c_ill),
        .retire_o(c_ret), .instret_o(c_instret)
    );

    function automatic logic [14:0] obs_d();
        return {d_pcw, d_adr, d_memw, d_irw, d_regw, d_res, d_a, d_b, d_aop, d_ill, d_ret};
    endfunction

    function automatic logic [14:0] obs_n();
        return {n_pcw, n_adr, n_memw, n_irw, n_regw, n_res, n_a, n_b, n_aop, n_ill, n_ret};
    endfunction

    function automatic logic [14:0] obs_c();
        return {c_pcw, c_adr, c_memw, c_irw, c_regw, c_res, c_a, c_b, c_aop, c_ill, c_ret};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        mem_ready = 1'b1;
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if (obs_d() !== S_FETCH_W) begin
            errors++;
            $display("FAIL reset_d: outputs=%b required %b", obs_d(), S_FETCH_W);
        end
        checks++;
        if (obs_n() !== S_FETCH_W) begin
            errors++;
            $display("FAIL reset_nj: outputs=%b required %b", obs_n(), S_FETCH_W);
        end
        checks++;
        if (d_instret !== 32'd0 || c_instret !== 4'd0) begin
            errors++;
            $display("FAIL reset_instret: d=%0d c=%0d required 0", d_instret, c_instret);
        end
        next_cycle();
        rst_ni = 1'b1;
    endtask

    task automatic test_lw();
        logic [14:0] exp [8];
        logic        rdy [8];
        exp = '{S_FETCH_W, S_FETCH_W, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMREAD, S_MEMWB};
        rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        op = 7'b0000011;
        funct3 = 3'b010;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #2;
            checks++;
            if (obs_d() !== exp[i]) begin
                errors++;
                $display("FAIL lw_cyc%0d: outputs=%b required %b", i, obs_d(), exp[i]);
            end
            next_cycle();
        end
        mem_ready = 1'b1;
        #2;
        checks++;
        if (d_instret !== 32'd1) begin
            errors++;
            $display("FAIL lw_instret: got %0d required 1", d_instret);
        end
    endtask

    task automatic test_branch();
        logic [2:0]  f3s [3];
        logic        zs  [3];
        logic [14:0] brs [3];
        f3s = '{3'b000, 3'b001, 3'b001};
        zs  = '{1'b1, 1'b1, 1'b0};
        brs = '{S_BR_T, S_BR_N, S_BR_T};
        op = 7'b1100011;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            funct3 = f3s[k];
            zero = zs[k];
            #2;
            checks++;
            if (obs_d() !== S_FETCH) begin
                errors++;
                $display("FAIL br%0d_fetch: outputs=%b required %b", k, obs_d(), S_FETCH);
            end
            next_cycle();
            #2;
            checks++;
            if (obs_d() !== S_DECODE || d_imm !== 3'b010) begin
                errors++;
                $display("FAIL br%0d_decode: outputs=%b imm=%b required %b imm=010", k, obs_d(),
                         d_imm, S_DECODE);
            end
            next_cycle();
            #2;
            checks++;
            if (obs_d() !== brs[k]) begin
                errors++;
                $display("FAIL br%0d_branch: outputs=%b required %b", k, obs_d(), brs[k]);
            end
            next_cycle();
        end
        zero = 1'b0;
        #2;
        checks++;
        if (d_instret !== 32'd4) begin
            errors++;
            $display("FAIL br_instret: got %0d required 4", d_instret);
        end
    endtask

    task automatic test_jalr();
        logic [14:0] exp_d [5];
        logic [14:0] exp_n [5];
        exp_d = '{S_FETCH, S_DECODE, S_JALRADR, S_JAL, S_ALUWB};
        exp_n = '{S_FETCH, S_DECODE, S_ILL, S_ILL, S_ILL};
        op = 7'b1100111;
        funct3 = 3'b000;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            checks++;
            if (obs_d() !== exp_d[i]) begin
                errors++;
                $display("FAIL jalr_cyc%0d: outputs=%b required %b", i, obs_d(), exp_d[i]);
            end
            checks++;
            if (obs_n() !== exp_n[i]) begin
                errors++;
                $display("FAIL jalr_off_cyc%0d: outputs=%b required %b", i, obs_n(), exp_n[i]);
            end
            next_cycle();
        end
        #2;
        checks++;
        if (d_instret !== 32'd5 || n_instret !== 32'd4) begin
            errors++;
            $display("FAIL jalr_instret: d=%0d nj=%0d required 5 and 4", d_instret, n_instret);
        end
    endtask

    task automatic test_utype();
        logic [6:0]  ops [2];
        logic [14:0] mid [2];
        ops = '{7'b0110111, 7'b0010111};
        mid = '{S_LUI, S_DECODE};
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            logic [14:0] exp [4];
            exp = '{S_FETCH, S_DECODE, mid[k], S_ALUWB};
            op = ops[k];
            for (int i = 0; i < 4; i++) begin
                #2;
                checks++;
                if (obs_d() !== exp[i] || d_imm !== 3'b100) begin
                    errors++;
                    $display("FAIL utype%0d_cyc%0d: outputs=%b imm=%b required %b imm=100", k, i,
                             obs_d(), d_imm, exp[i]);
                end
                checks++;
                if (obs_n() !== S_ILL) begin
                    errors++;
                    $display("FAIL nj_stuck_illegal: outputs=%b required %b", obs_n(), S_ILL);
                end
                next_cycle();
            end
        end
        #2;
        checks++;
        if (d_instret !== 32'd7) begin
            errors++;
            $display("FAIL utype_instret: got %0d required 7", d_instret);
        end
    endtask

    task automatic test_sw_reset();
        logic [14:0] exp [4];
        logic        rdy [4];
        exp = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR_W};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
        op = 7'b0100011;
        funct3 = 3'b010;
        for (int i = 0; i < 4; i++) begin
            mem_ready = rdy[i];
            #2;
            checks++;
            if (obs_d() !== exp[i]) begin
                errors++;
                $display("FAIL sw_cyc%0d: outputs=%b required %b", i, obs_d(), exp[i]);
            end
            next_cycle();
        end
        mem_ready = 1'b0;
        #2;
        checks++;
        if (obs_d() !== S_MEMWR_W || d_instret !== 32'd7) begin
            errors++;
            $display("FAIL sw_wait2: outputs=%b instret=%0d required %b instret=7", obs_d(),
                     d_instret, S_MEMWR_W);
        end
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if (d_memw !== 1'b0 || obs_d() !== S_FETCH_W) begin
            errors++;
            $display("FAIL sw_async_reset: memwrite=%b outputs=%b required 0 and %b", d_memw,
                     obs_d(), S_FETCH_W);
        end
        checks++;
        if (d_instret !== 32'd0) begin
            errors++;
            $display("FAIL sw_reset_instret: got %0d required 0", d_instret);
        end
        next_cycle();
        mem_ready = 1'b1;
        #2;
        checks++;
        if (obs_d() !== S_FETCH_W) begin
            errors++;
            $display("FAIL reset_held_strobes: outputs=%b required %b", obs_d(), S_FETCH_W);
        end
        next_cycle();
        rst_ni = 1'b1;
    endtask

    task automatic test_illegal_branch();
        logic [14:0] exp [5];
        exp = '{S_FETCH, S_DECODE, S_ILL, S_ILL, S_ILL};
        op = 7'b1100011;
        funct3 = 3'b100;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            checks++;
            if (obs_d() !== exp[i]) begin
                errors++;
                $display("FAIL blt_illegal_cyc%0d: outputs=%b required %b", i, obs_d(), exp[i]);
            end
            next_cycle();
        end
        apply_reset();
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        op = 7'b0110011;
        funct3 = 3'b000;
        mem_ready = 1'b1;
        #2;
        checks++;
        if (obs_n() !== S_FETCH) begin
            errors++;
            $display("FAIL nj_after_reset: outputs=%b required %b", obs_n(), S_FETCH);
        end
        for (int c = 0; c <= 68; c++) begin
            if (c > 0) #2;
            if (c % 4 == 0) begin
                checks++;
                if (c_instret !== 4'((c / 4) % 16)) begin
                    errors++;
                    $display("FAIL b2b_instret_%0d: got %0d required %0d", c / 4, c_instret,
                             (c / 4) % 16);
                end
            end
            if (c < 68) begin
                if (c_ret === 1'b1) pulses++;
                checks++;
                if (c_ret !== (c % 4 == 3)) begin
                    errors++;
                    $display("FAIL b2b_retire_cyc%0d: got %b required %b", c, c_ret, c % 4 == 3);
                end
                next_cycle();
            end
        end
        checks++;
        if (pulses != 17 || d_instret !== 32'd17) begin
            errors++;
            $display("FAIL b2b_totals: pulses=%0d d_instret=%0d required 17 and 17", pulses,
                     d_instret);
        end
    endtask

    initial begin
        fork
            begin
                #100000;
                $display("FAIL timeout: simulation still running at %0t", $time);
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_lw();
        test_branch();
        test_jalr();
        test_utype();
        test_sw_reset();
        test_illegal_branch();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
